pdm_meter_src: RTL and testbench
================================

# pdm_meter_src

Dual-channel audio-to-PDM stage sitting directly upstream of the LED level driver. It latches left/right signed 16-bit equalizer samples on `vld` and runs a first-order sigma-delta modulator per channel at a programmable bit rate. It also produces a per-channel magnitude (peak-hold with decay) that the LED stage uses for level thresholds. The `lft_PDM`/`rght_PDM` outputs feed both the LED driver and the audio output pins.

## Interface
- `PDM_DIV`, default 4: clk cycles per PDM bit (≥1).
- `DECAY_SAMPLES`, default 1024: number of accepted samples between peak decay steps (≥2).
- `DECAY_SHIFT`, default 3: on each decay step, peak loses peak>>DECAY_SHIFT.
- `clk  input  1`: system clock.
- `rst  input  1`: synchronous, active-high reset.
- `vld  input  1`: one-cycle strobe; sample inputs valid.
- `aud_out_lft  input  16`: left sample, two's complement.
- `aud_out_rght  input  16`: right sample, two's complement.
- `lft_PDM  output  1`: left PDM bit stream, registered.
- `rght_PDM  output  1`: right PDM bit stream, registered.
- `lft_mag  output  16`: left magnitude, unsigned 0..0x7FFF, registered.
- `rght_mag  output  16`: right magnitude, unsigned 0..0x7FFF, registered.

## Operation
- Sample latch: on `vld`, `smp_x <= aud_out_x ^ 16'h8000` (offset binary; -32768→0x0000, 0→0x8000, 32767→0xFFFF). Without `vld`, hold.
- Bit-rate divider: `div_cnt` counts 0..PDM_DIV-1 and wraps; `tick` = (div_cnt == PDM_DIV-1). With PDM_DIV=1, `tick` is asserted every cycle.
- Modulator per channel, on `tick` only: {c, acc} = acc + smp (17-bit sum); acc <= low 16 bits; PDM <= c. Long-run ones density = smp/65536.
- Magnitude abs: abs(aud_out_x), with -32768 saturated to 0x7FFF.
- Peak hold, on `vld` only: `dec_cnt` counts accepted samples 0..DECAY_SAMPLES-1 and wraps. On the wrap sample, base = mag - (mag>>DECAY_SHIFT); otherwise base = mag. Then mag <= max(abs, base).
- Channels are independent except for the shared divider and decay counter.

## Timing
- Reset (`rst` high at a clk edge): smp=0x8000 (silence), acc=0, div_cnt=0, dec_cnt=0, `lft_PDM`=`rght_PDM`=0, `lft_mag`=`rght_mag`=0. Reset mid-stream discards the latched sample and accumulator state. The first `tick` after reset occurs PDM_DIV cycles after the release edge.
- Latency: a sample latched at edge N is used by the first `tick` edge strictly after N. If `vld` and `tick` fall on the same edge, that tick uses the old sample.
- PDM outputs change only on `tick` edges and are stable otherwise.
- Magnitude outputs update one edge after `vld`.
- Back-to-back `vld`: every strobe is accepted and the last one wins. No backpressure exists.
- No overflow is possible; the carry is the output bit by design.

## Configuration
- `PEAK_HOLD_EN` defined: peak-hold with decay as described above.
- `PEAK_HOLD_EN` undefined: mag <= abs on each `vld` (instantaneous magnitude). `dec_cnt` and the decay logic are removed, and the `DECAY_*` parameters are ignored.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs, then release -> both PDM outputs =0 and both mags =0. With no `vld`, PDM_DIV=1, the outputs toggle 0,1,0,1… starting at the first tick.
- Full scale: PDM_DIV=1, `vld` with lft=0x7FFF and rght=0x8000 -> over 65536 ticks, the lft_PDM count of ones is 65535 and the rght_PDM count of ones is 0.
- Quarter density: PDM_DIV=4, lft=0xC000 (offset 0x4000) -> lft_PDM repeats 0,0,0,1 with bits each 4 cycles wide, and changes only on tick edges.
- Abs saturation: `vld` with lft=0x8000 and rght=0xFFFF -> next cycle lft_mag=0x7FFF, rght_mag=0x0001.
- Peak decay (`PEAK_HOLD_EN`, DECAY_SAMPLES=4, DECAY_SHIFT=3): one sample of 0x4000 on lft, then three samples of 0 (wrap sample) -> lft_mag stays 0x4000 until the wrap, then becomes 0x3800. A larger sample on a wrap sample overrides the decay.
- Same-edge `vld`/tick and mid-stream reset: `vld` coincident with a tick -> that tick uses the old sample. Asserting `rst` mid-stream -> all state is at reset values on the next cycle.

Source files
------------

// File: rtl/pdm_meter_src.sv
// pdm_meter_src: dual-channel first-order sigma-delta PDM stage with a
// per-channel magnitude output for the downstream LED level thresholds.
// Optional feature macro: PEAK_HOLD_EN -- when defined, the magnitude is a
// peak hold that decays every DECAY_SAMPLES accepted samples; when undefined
// the magnitude is the instantaneous absolute value of the last sample.
module pdm_meter_src #(
   parameter int PDM_DIV       = 4,
   parameter int DECAY_SAMPLES = 1024,
   parameter int DECAY_SHIFT   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vld,
   input  logic [15:0] aud_out_lft,
   input  logic [15:0] aud_out_rght,
   output logic        lft_PDM,
   output logic        rght_PDM,
   output logic [15:0] lft_mag,
   output logic [15:0] rght_mag
);

   localparam int               DIV_W    = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PDM_DIV - 1);

   // Reject nonsensical configurations at elaboration time
   if (PDM_DIV < 1 || DECAY_SAMPLES < 2 || DECAY_SHIFT < 0) begin : g_bad_cfg
      $error("pdm_meter_src: PDM_DIV must be >=1, DECAY_SAMPLES >=2, DECAY_SHIFT >=0");
   end

   // Both channels indexed 0 = left, 1 = right
   logic [1:0][15:0] aud_in;
   assign aud_in = {aud_out_rght, aud_out_lft};

   logic [DIV_W-1:0] div_cnt_reg;
   logic             tick;

   // With PDM_DIV=1 the counter sits at 0 and tick is asserted every cycle
   assign tick = (div_cnt_reg == DIV_LAST);

   // Shared bit-rate divider: one modulator step every PDM_DIV cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_reg <= '0;
      end else if (tick) begin
         div_cnt_reg <= '0;
      end else begin
         div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
   end

`ifdef PEAK_HOLD_EN
   localparam int               DEC_W    = $clog2(DECAY_SAMPLES);
   localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_SAMPLES - 1);

   logic [DEC_W-1:0] dec_cnt_reg;
   logic             dec_wrap;

   // The sample accepted while the counter is at its last value is the decay sample
   assign dec_wrap = (dec_cnt_reg == DEC_LAST);

   // Shared decay counter, advanced once per accepted sample
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_cnt_reg <= '0;
      end else if (vld) begin
         dec_cnt_reg <= dec_wrap ? '0 : dec_cnt_reg + DEC_W'(1);
      end
   end
`endif

   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [15:0] smp_reg;
      logic [15:0] acc_reg;
      logic        pdm_reg;
      logic [15:0] mag_reg;
      logic [16:0] sum;
      logic [15:0] abs_val;
      logic [15:0] mag_next;

      // The carry out of the accumulator is the PDM bit; it can never overflow
      assign sum = {1'b0, acc_reg} + {1'b0, smp_reg};

      // Absolute value; -32768 has no positive counterpart so it saturates
      always_comb begin
         abs_val = aud_in[gi];
         if (aud_in[gi] == 16'h8000) begin
            abs_val = 16'h7FFF;
         end else if (aud_in[gi][15]) begin
            abs_val = ~aud_in[gi] + 16'd1;
         end
      end

`ifdef PEAK_HOLD_EN
      logic [15:0] base;

      // Peak hold: decay the held value on the wrap sample, then keep the larger
      always_comb begin
         base = mag_reg;
         if (dec_wrap) begin
            base = mag_reg - (mag_reg >> DECAY_SHIFT);
         end
         mag_next = (abs_val > base) ? abs_val : base;
      end
`else
      assign mag_next = abs_val;
`endif

      // Sample latch (offset binary) and sigma-delta modulator step on tick;
      // a tick coinciding with vld still sees the previously latched sample
      always_ff @(posedge clk) begin
         if (rst) begin
            smp_reg <= 16'h8000;
            acc_reg <= '0;
            pdm_reg <= 1'b0;
         end else begin
            if (vld) begin
               smp_reg <= aud_in[gi] ^ 16'h8000;
            end
            if (tick) begin
               acc_reg <= sum[15:0];
               pdm_reg <= sum[16];
            end
         end
      end

      // Magnitude register, updated once per accepted sample
      always_ff @(posedge clk) begin
         if (rst) begin
            mag_reg <= '0;
         end else if (vld) begin
            mag_reg <= mag_next;
         end
      end
   end

   assign lft_PDM  = g_chan[0].pdm_reg;
   assign rght_PDM = g_chan[1].pdm_reg;
   assign lft_mag  = g_chan[0].mag_reg;
   assign rght_mag = g_chan[1].mag_reg;

endmodule

// File: tb/tb_pdm_meter_src.sv
// tb_pdm_meter_src: two instances (PDM_DIV=1 and PDM_DIV=4, both with
// DECAY_SAMPLES=4, DECAY_SHIFT=3) driven from shared stimulus.
// Magnitude expectations flow through a queue: pushed when vld is driven,
// popped and compared on the edge the magnitude registers update.
// Honours PEAK_HOLD_EN the same way the design does.
module tb_pdm_meter_src;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld;
   logic [15:0] lft_in;
   logic [15:0] rght_in;

   logic        d1_lp, d1_rp, d4_lp, d4_rp;
   logic [15:0] d1_lm, d1_rm, d4_lm, d4_rm;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic [15:0] el;
      logic [15:0] er;
   } mag_vec_t;

   typedef struct {
      logic [15:0] el;
      logic [15:0] er;
   } mag_exp_t;

   mag_exp_t sb_q[$];
   mag_vec_t abs_tbl[6];
   mag_vec_t peak_tbl[9];

   always #5 clk = ~clk;

   pdm_meter_src #(.PDM_DIV(1), .DECAY_SAMPLES(4), .DECAY_SHIFT(3)) u_d1 (
      .clk(clk), .rst(rst), .vld(vld),
      .aud_out_lft(lft_in), .aud_out_rght(rght_in),
      .lft_PDM(d1_lp), .rght_PDM(d1_rp), .lft_mag(d1_lm), .rght_mag(d1_rm)
   );

   pdm_meter_src #(.PDM_DIV(4), .DECAY_SAMPLES(4), .DECAY_SHIFT(3)) u_d4 (
      .clk(clk), .rst(rst), .vld(vld),
      .aud_out_lft(lft_in), .aud_out_rght(rght_in),
      .lft_PDM(d4_lp), .rght_PDM(d4_rp), .lft_mag(d4_lm), .rght_mag(d4_rm)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   // One vld strobe; the expectation rides the queue until the magnitude updates
   task automatic send_vld(input logic [15:0] l, input logic [15:0] r,
                           input logic [15:0] el, input logic [15:0] er, input string tag);
      mag_exp_t e;
      lft_in  = l;
      rght_in = r;
      vld     = 1'b1;
      e.el = el;
      e.er = er;
      sb_q.push_back(e);
      step();
      vld = 1'b0;
      if (sb_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         $display("vld %s: lft=%h rght=%h -> mag d1 %h/%h d4 %h/%h (exp %h/%h)",
                  tag, l, r, d1_lm, d1_rm, d4_lm, d4_rm, e.el, e.er);
         check({tag, "_d1_lft_mag"},  {16'd0, d1_lm}, {16'd0, e.el});
         check({tag, "_d1_rght_mag"}, {16'd0, d1_rm}, {16'd0, e.er});
         check({tag, "_d4_lft_mag"},  {16'd0, d4_lm}, {16'd0, e.el});
         check({tag, "_d4_rght_mag"}, {16'd0, d4_rm}, {16'd0, e.er});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_d1_lft_pdm"},  {31'd0, d1_lp}, 32'd0);
      check({tag, "_d1_rght_pdm"}, {31'd0, d1_rp}, 32'd0);
      check({tag, "_d4_lft_pdm"},  {31'd0, d4_lp}, 32'd0);
      check({tag, "_d4_rght_pdm"}, {31'd0, d4_rp}, 32'd0);
      check({tag, "_d1_lft_mag"},  {16'd0, d1_lm}, 32'd0);
      check({tag, "_d1_rght_mag"}, {16'd0, d1_rm}, 32'd0);
      check({tag, "_d4_lft_mag"},  {16'd0, d4_lm}, 32'd0);
      check({tag, "_d4_rght_mag"}, {16'd0, d4_rm}, 32'd0);
   endtask

   initial begin
      int cnt_l;
      int cnt_r;
      logic exp_l;
      logic exp_r;

      rst     = 1'b1;
      vld     = 1'b0;
      lft_in  = '0;
      rght_in = '0;

      // Absolute-value vectors, each applied from a fresh reset
      abs_tbl[0] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001};
      abs_tbl[1] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0001};
      abs_tbl[2] = '{16'h0000, 16'h8001, 16'h0000, 16'h7FFF};
      abs_tbl[3] = '{16'hFF00, 16'h0100, 16'h0100, 16'h0100};
      abs_tbl[4] = '{16'hC000, 16'h4000, 16'h4000, 16'h4000};
      abs_tbl[5] = '{16'h1234, 16'hEDCC, 16'h1234, 16'h1234};

      // Back-to-back samples; the 4th and 8th are decay (wrap) samples
`ifdef PEAK_HOLD_EN
      peak_tbl[0] = '{16'h4000, 16'h0800, 16'h4000, 16'h0800};
      peak_tbl[1] = '{16'h0000, 16'h0000, 16'h4000, 16'h0800};
      peak_tbl[2] = '{16'h0000, 16'h0000, 16'h4000, 16'h0800};
      peak_tbl[3] = '{16'h0000, 16'h0000, 16'h3800, 16'h0700};
      peak_tbl[4] = '{16'h0000, 16'h0000, 16'h3800, 16'h0700};
      peak_tbl[5] = '{16'h0000, 16'h0000, 16'h3800, 16'h0700};
      peak_tbl[6] = '{16'h0000, 16'h0000, 16'h3800, 16'h0700};
      peak_tbl[7] = '{16'h3C00, 16'h0100, 16'h3C00, 16'h0620};
      peak_tbl[8] = '{16'h0000, 16'h0000, 16'h3C00, 16'h0620};
`else
      peak_tbl[0] = '{16'h4000, 16'h0800, 16'h4000, 16'h0800};
      peak_tbl[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      peak_tbl[2] = '{16'h0000, 16'hF800, 16'h0000, 16'h0800};
      peak_tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      peak_tbl[4] = '{16'hC000, 16'h0000, 16'h4000, 16'h0000};
      peak_tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      peak_tbl[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
      peak_tbl[7] = '{16'h3C00, 16'h0100, 16'h3C00, 16'h0100};
      peak_tbl[8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif

      // Reset held two cycles with random inputs and strobes
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         lft_in  = 16'($urandom);
         rght_in = 16'($urandom);
         vld     = 1'($urandom);
         step();
      end
      rst = 1'b0;
      vld = 1'b0;
      check_all_zero("reset");

      // Silence with PDM_DIV=1 toggles 0,1,0,1 from the first tick
      for (int k = 1; k <= 8; k++) begin
         step();
         exp_l = ((k % 2) == 0);
         $display("silence k=%0d: d1 pdm %b/%b exp %b", k, d1_lp, d1_rp, exp_l);
         check($sformatf("silence_k%0d_lft", k),  {31'd0, d1_lp}, {31'd0, exp_l});
         check($sformatf("silence_k%0d_rght", k), {31'd0, d1_rp}, {31'd0, exp_l});
      end

      // Table-driven absolute value / saturation vectors
      for (int i = 0; i < 6; i++) begin
         do_reset(1);
         send_vld(abs_tbl[i].l, abs_tbl[i].r, abs_tbl[i].el, abs_tbl[i].er,
                  $sformatf("abs%0d", i));
      end

      // Magnitude sequence (peak hold with decay, or instantaneous)
      do_reset(1);
      for (int i = 0; i < 9; i++) begin
         send_vld(peak_tbl[i].l, peak_tbl[i].r, peak_tbl[i].el, peak_tbl[i].er,
                  $sformatf("peak%0d", i));
      end

      // Quarter density on PDM_DIV=4: lft offset 0x4000, rght offset 0x8000
      do_reset(1);
      send_vld(16'hC000, 16'h0000, 16'h4000, 16'h0000, "quarter");
      for (int k = 1; k <= 32; k++) begin
         if (k > 1) step();
         exp_l = (k >= 4) && (((k / 4) % 4) == 0);
         exp_r = (k >= 4) && (((k / 4) % 2) == 0);
         $display("quarter k=%0d: d4 pdm %b/%b exp %b/%b", k, d4_lp, d4_rp, exp_l, exp_r);
         check($sformatf("quarter_k%0d_lft", k),  {31'd0, d4_lp}, {31'd0, exp_l});
         check($sformatf("quarter_k%0d_rght", k), {31'd0, d4_rp}, {31'd0, exp_r});
      end

      // Same-edge vld and tick on PDM_DIV=1: the tick still uses the old sample
      do_reset(1);
      step();
      check("same_edge_pre_lft", {31'd0, d1_lp}, 32'd0);
      send_vld(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, "same_edge");
      check("same_edge_old_lft",  {31'd0, d1_lp}, 32'd1);
      check("same_edge_old_rght", {31'd0, d1_rp}, 32'd1);
      step();
      check("same_edge_new1_lft",  {31'd0, d1_lp}, 32'd0);
      check("same_edge_new1_rght", {31'd0, d1_rp}, 32'd0);
      step();
      check("same_edge_new2_lft",  {31'd0, d1_lp}, 32'd0);
      check("same_edge_new2_rght", {31'd0, d1_rp}, 32'd1);

      // Mid-stream reset discards sample, accumulator and divider phase
      do_reset(1);
      for (int i = 0; i < 10; i++) begin
         lft_in  = 16'($urandom);
         rght_in = 16'($urandom);
         vld     = 1'($urandom);
         step();
      end
      vld = 1'b0;
      send_vld(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, "pre_reset");
      repeat (3) step();
      do_reset(1);
      check_all_zero("midreset");
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k <= 2) begin
            exp_l = (k == 2);
            check($sformatf("midreset_d1_k%0d_lft", k), {31'd0, d1_lp}, {31'd0, exp_l});
         end
         if (k == 3 || k == 4 || k == 8 || k == 12) begin
            exp_l = (k == 8);
            $display("midreset k=%0d: d4 pdm %b/%b exp %b", k, d4_lp, d4_rp, exp_l);
            check($sformatf("midreset_d4_k%0d_lft", k),  {31'd0, d4_lp}, {31'd0, exp_l});
            check($sformatf("midreset_d4_k%0d_rght", k), {31'd0, d4_rp}, {31'd0, exp_l});
         end
      end

      // Full scale on PDM_DIV=1 over 65536 ticks
      do_reset(1);
      send_vld(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, "full_scale");
      cnt_l = 0;
      cnt_r = 0;
      for (int k = 0; k < 65536; k++) begin
         step();
         cnt_l += int'(d1_lp);
         cnt_r += int'(d1_rp);
      end
      $display("full scale: lft ones %0d (exp 65535), rght ones %0d (exp 0)", cnt_l, cnt_r);
      check("full_scale_lft_ones",  32'(cnt_l), 32'd65535);
      check("full_scale_rght_ones", 32'(cnt_r), 32'd0);

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
